// File: rtl/s_cnt_feeder.sv
// -----------------------------------------------------------------------------
// s_cnt_feeder
//   Command feeder for the shift counter s_cnt. Values arrive over a
//   valid/ready handshake and are buffered in a small circular FIFO. While
//   idle, the sequencer takes the FIFO head, presents it on num with a
//   one-cycle start pulse, and then holds off for RUN_CYC cycles so that
//   s_cnt can finish its run before the next value is issued.
//
// Ports
//   clk       in   1    rising-edge clock
//   rst       in   1    asynchronous, active-high reset
//   in_valid  in   1    upstream value valid
//   in_data   in   DW   upstream value
//   in_ready  out  1    FIFO not full (combinational)
//   num       out  DW   value presented to s_cnt (registered)
//   start     out  1    one-cycle load pulse to s_cnt (registered)
//   busy      out  1    sequencer running or FIFO non-empty
//   issued    out  8    number of start pulses issued, wraps 255 -> 0
// -----------------------------------------------------------------------------
module s_cnt_feeder #(
    parameter int DW      = 4,
    parameter int DEPTH   = 4,   // power of two, >= 2
    parameter int RUN_CYC = 8    // >= 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [DW-1:0] num,
    output logic          start,
    output logic          busy,
    output logic [7:0]    issued
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (RUN_CYC > 1) ? $clog2(RUN_CYC) : 1;
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TIMER_RLD = TW'(RUN_CYC - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // FIFO storage and bookkeeping
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    // Sequencer state and registered outputs
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [DW-1:0] r_num;
    logic          r_start;
    logic [7:0]    r_issued;

    // Next-state values
    state_t        w_state_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic [DW-1:0] w_num_nxt;
    logic          w_start_nxt;
    logic [7:0]    w_issued_nxt;

    logic          w_push;
    logic          w_pop;

    assign in_ready = (r_count != FULL_CNT);
    assign busy     = (r_state != ST_IDLE) || (r_count != '0);
    assign num      = r_num;
    assign start    = r_start;
    assign issued   = r_issued;

    // Pop is decided from registered occupancy only, so a value written on
    // this edge into an empty FIFO is not visible to the sequencer until the
    // next edge (no bypass path).
    assign w_push = in_valid && in_ready;

    // NOTE: the storage array has no reset; entries are only read after being
    // written, and leaving it out of the reset net keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;   // wraps modulo DEPTH
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: every signal driven here gets its default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_num_nxt    = r_num;
        w_start_nxt  = 1'b0;
        w_issued_nxt = r_issued;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_num_nxt    = r_mem[r_rptr];
                    w_start_nxt  = 1'b1;
                    w_timer_nxt  = TIMER_RLD;
                    w_issued_nxt = r_issued + 8'd1;
                    w_state_nxt  = ST_RUN;
                end
            end
            ST_RUN: begin
                // Timer counts RUN_CYC-1 .. 0, then one more edge returns to
                // IDLE, giving RUN_CYC+1 cycles between back-to-back issues.
                if (r_timer != '0) begin
                    w_timer_nxt = r_timer - 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_num    <= '0;
            r_start  <= 1'b0;
            r_issued <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_num    <= w_num_nxt;
            r_start  <= w_start_nxt;
            r_issued <= w_issued_nxt;
        end
    end

endmodule

// File: doc/s_cnt_feeder.md
# s_cnt_feeder

Command feeder placed directly upstream of the shift counter `s_cnt`. It accepts 4-bit values over a valid/ready interface and buffers them in a small FIFO. It presents one value at a time on `num` with a one-cycle `start` pulse, then holds `num` stable for a fixed run window before issuing the next value. This replaces the hand-driven `num`/`start` stimulus with a reusable sequencing stage.

## Interface

Parameters:
- `DW`, 4: data width of `in_data` and `num`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RUN_CYC`, 8: cycles reserved per `s_cnt` run after the `start` cycle; ≥1.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  upstream value valid.
- `in_data`  in  DW  upstream value.
- `in_ready`  out  1  FIFO can accept; combinational, equals not full.
- `num`  out  DW  value presented to `s_cnt`; registered.
- `start`  out  1  one-cycle load pulse to `s_cnt`; registered.
- `busy`  out  1  high when the state is not IDLE or the FIFO is non-empty; combinational from registers.
- `issued`  out  8  count of start pulses issued; registered; wraps 255→0.

## Operation

- FIFO: circular buffer with write pointer, read pointer, and occupancy counter (0..DEPTH).
  - Push on a rising edge when `in_valid && in_ready`.
  - Pop only from the FSM in IDLE.
  - No bypass: a value pushed into an empty FIFO is not popped on the same edge.
- Full: `in_ready`=0. `in_valid` is ignored and the data is not stored. Upstream must hold the value.
- Empty: no pop; the FSM stays in IDLE.
- Simultaneous push and pop (FIFO neither full nor empty): both occur and occupancy is unchanged. When full, a pop frees a slot only from the next cycle onward.
- Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: when occupancy≠0 at an edge, set `num`←head, pop, `start`←1, `timer`←RUN_CYC−1, `issued`←`issued`+1, and go to RUN.
  - RUN: `start`←0. If `timer`≠0, decrement it. If `timer`==0, go to IDLE.
- `num` holds its last issued value through IDLE; it changes only on an issue edge.
- All values, including 0, are issued unchanged.
- Reset (asynchronous, any time, including mid-RUN or while `start`=1):
  - FIFO emptied and pointers cleared.
  - State=IDLE, `timer`=0, `num`=0, `start`=0, `issued`=0.
  - Resulting outputs: `in_ready`=1, `busy`=0.
  - No start pulse completes after reset asserts.

## Timing

- Push-to-start latency into an empty, idle block: value accepted at edge t; `start`=1 and `num` valid from edge t+1 to edge t+2.
- `start` is high for exactly one cycle per issued value. `num` is valid in the same cycle as `start`.
- Issue spacing with a backlog: consecutive `start` rising edges are exactly RUN_CYC+1 cycles apart, i.e. 9 cycles at the defaults.
- Last issue with the FIFO empty: the FSM leaves RUN RUN_CYC cycles after the issue edge. `busy` falls on that edge.
- `in_ready` reacts combinationally to occupancy. After a pop from full, it rises in the cycle following the pop edge.
- `issued` updates on the same edge that `start` rises.

## Test plan

- Reset then single value: release `rst`, push 4'h8 once. Expect `start`=1 for one cycle with `num`=8, one cycle after acceptance. Expect `issued`=1 and `busy` low 8 cycles after the start edge.
- Backlog: push 1,2,3,4 on consecutive cycles. Expect `in_ready` stays 1 for all four pushes. Expect starts with `num`=1,2,3,4 in order, spaced exactly 9 cycles apart. Expect `issued`=4.
- Full: push 5 values back-to-back with `in_valid` held. Expect `in_ready`=0 once 4 are held after the first pop is accounted for. The 5th value is accepted only after a pop, and the issue order is preserved.
- Wrap-around: stream 10 values (0..9) through the FIFO. Expect every value issued once, in order, confirming pointer wrap. Expect `issued`=10.
- Reset mid-run: assert `rst` 3 cycles after a start with 2 values still queued. Expect `start`=0, `num`=0, `issued`=0, `busy`=0, `in_ready`=1 immediately. Expect no further starts after release until a new push.
- Zero value and counter wrap: issue 256 values including 0. Expect 0 issued on `num` with `start`. Expect `issued` to wrap to 0.
